// File: rtl/cmd_arbiter_pkg.sv
// cmd_arbiter_pkg: shared PSL requester ids, command codes and tag layout
package cmd_arbiter_pkg;
  localparam logic [1:0] REQ_MISC = 2'd0;
  localparam logic [1:0] REQ_READ = 2'd1;
  localparam logic [1:0] REQ_WRITE = 2'd2;
  localparam logic [1:0] TAG_BAD_ID = 2'd3;
  localparam logic [12:0] PSL_CMD_READ = 13'h0A00;
  localparam logic [12:0] PSL_CMD_WRITE = 13'h0D00;
  localparam int SEQ_W = 6;
  localparam int ID_W = 2;
  localparam int TAG_W = SEQ_W + ID_W;
  function automatic logic [TAG_W-1:0] make_tag(logic [SEQ_W-1:0] seq, logic [ID_W-1:0] id);
    return {seq, id};
  endfunction
endpackage

// File: rtl/cmd_arbiter_rr_pick3.sv
// rr_pick3: combinational 3-way round-robin winner select starting at ptr
module rr_pick3
  import cmd_arbiter_pkg::*;
(
  input  logic [2:0] elig,
  input  logic [1:0] ptr,
  output logic [1:0] win,
  output logic       vld
);
  logic [1:0] p0, p1, p2;
  always_comb begin
    p0 = ptr == TAG_BAD_ID ? REQ_MISC : ptr;
    p1 = p0 == REQ_WRITE ? REQ_MISC : p0 + 2'd1;
    p2 = p1 == REQ_WRITE ? REQ_MISC : p1 + 2'd1;
    vld = |elig;
    win = elig[p0] ? p0 : elig[p1] ? p1 : p2;
  end
endmodule

// File: rtl/cmd_arbiter.sv
// cmd_arbiter: credit-limited round-robin PSL command issue with tagged response routing
module cmd_arbiter
  import cmd_arbiter_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int NREQ = 3
) (
  input  logic             ha_pclock,
  input  logic             reset,
  input  logic [0:2]       req,
  input  logic [0:2][0:12] req_com,
  input  logic [0:2][0:63] req_ea,
  output logic [0:2]       gnt,
  output logic             ah_cvalid,
  output logic [0:7]       ah_ctag,
  output logic [0:12]      ah_com,
  output logic [0:63]      ah_cea,
  input  logic             ha_rvalid,
  input  logic [0:7]       ha_rtag,
  input  logic [0:7]       ha_response,
  output logic [0:2]       rsp_done,
  output logic [0:7]       rsp_code,
  output logic             busy,
  output logic             tag_err
);
  localparam int CW = $clog2(CREDITS + 1);
  logic [0:2] pending;
  logic [SEQ_W-1:0] seq;
  logic [1:0] rr_ptr, win, rid;
  logic [CW-1:0] credits;
  logic [2:0] elig;
  logic issue, rsp_pend, rsp_hit, unused_tag_bits;
  for (genvar i = 0; i < NREQ; i++) begin : g_elig
    assign elig[i] = req[i] && !pending[i] && credits != '0;
  end
  rr_pick3 u_pick (.elig(elig), .ptr(rr_ptr), .win(win), .vld(issue));
  assign rid = ha_rtag[6:7];
  assign rsp_pend = rid == REQ_MISC ? pending[0] : rid == REQ_READ ? pending[1] : pending[2];
  assign rsp_hit = ha_rvalid && rid != TAG_BAD_ID && rsp_pend;
  assign busy = |pending;
  assign unused_tag_bits = ^ha_rtag[0:5];
  always_ff @(posedge ha_pclock) begin
    if (reset) begin
      ah_cvalid <= 1'b0;
      gnt <= '0;
      rsp_done <= '0;
      rsp_code <= '0;
      ah_ctag <= '0;
      ah_com <= '0;
      ah_cea <= '0;
      tag_err <= 1'b0;
      pending <= '0;
      seq <= '0;
      rr_ptr <= REQ_MISC;
      credits <= CW'(CREDITS);
    end else begin
      ah_cvalid <= issue;
      for (int i = 0; i < NREQ; i++) begin
        gnt[i] <= issue && win == 2'(i);
        rsp_done[i] <= rsp_hit && rid == 2'(i);
        pending[i] <= (pending[i] && !(rsp_hit && rid == 2'(i))) || (issue && win == 2'(i));
      end
      if (issue) begin
        ah_com <= req_com[win];
        ah_cea <= req_ea[win];
        ah_ctag <= make_tag(seq, win);
        seq <= seq + 6'd1;
        rr_ptr <= win == REQ_WRITE ? REQ_MISC : win + 2'd1;
      end
      if (rsp_hit) rsp_code <= ha_response;
      if (ha_rvalid && !rsp_hit) tag_err <= 1'b1;
      credits <= credits - CW'(issue) + CW'(rsp_hit);
    end
  end
endmodule

// File: tb/tb_cmd_arbiter.sv
// tb_cmd_arbiter: scoreboard bench with a queue-based reference model of the arbiter
module tb_cmd_arbiter;
  import cmd_arbiter_pkg::*;
  localparam int CREDITS = 2;
  typedef struct {
    logic [7:0]  tag;
    logic [12:0] com;
    logic [63:0] ea;
    logic [0:2]  g;
  } cmd_t;
  typedef struct {
    logic [0:2] d;
    logic [7:0] code;
  } rsp_t;
  logic clk = 0, reset = 1;
  logic [0:2] req = '0;
  logic [0:2][0:12] req_com = '0;
  logic [0:2][0:63] req_ea = '0;
  logic [0:2] gnt, rsp_done;
  logic ah_cvalid, busy, tag_err;
  logic [0:7] ah_ctag, rsp_code;
  logic [0:12] ah_com;
  logic [0:63] ah_cea;
  logic ha_rvalid = 0;
  logic [0:7] ha_rtag = '0, ha_response = '0;
  int n_chk = 0, n_err = 0, n_issue = 0;
  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int ord_q[$];
  logic [7:0] tag_q[$];
  bit m_pend[3];
  logic [7:0] m_tag_of[3];
  int m_cred = CREDITS, m_rr = 0, m_seq = 0, m_id, m_w, m_just_id = 0;
  bit m_terr = 0, m_ok, m_just = 0;
  logic [7:0] m_code = '0, m_just_tag = '0;
  cmd_t m_c;
  always #5 clk = ~clk;
  cmd_arbiter #(.CREDITS(CREDITS)) dut (
    .ha_pclock(clk), .reset(reset), .req(req), .req_com(req_com), .req_ea(req_ea),
    .gnt(gnt), .ah_cvalid(ah_cvalid), .ah_ctag(ah_ctag), .ah_com(ah_com), .ah_cea(ah_cea),
    .ha_rvalid(ha_rvalid), .ha_rtag(ha_rtag), .ha_response(ha_response),
    .rsp_done(rsp_done), .rsp_code(rsp_code), .busy(busy), .tag_err(tag_err)
  );
  function automatic logic [0:2] onehot(int i);
    logic [0:2] g = '0;
    g[i] = 1'b1;
    return g;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    m_just = 0;
    if (reset) begin
      m_pend = '{0, 0, 0};
      m_cred = CREDITS;
      m_rr = 0;
      m_seq = 0;
      m_terr = 0;
      m_code = '0;
    end else begin
      m_id = int'(ha_rtag) % 4;
      m_ok = ha_rvalid && m_id < 3 && m_pend[m_id];
      if (ha_rvalid && !m_ok) m_terr = 1;
      m_w = -1;
      if (m_cred > 0)
        for (int k = 0; k < 3; k++)
          if (m_w < 0 && req[(m_rr + k) % 3] && !m_pend[(m_rr + k) % 3]) m_w = (m_rr + k) % 3;
      if (m_ok) begin
        m_pend[m_id] = 0;
        m_cred++;
        m_code = ha_response;
        rsp_q.push_back('{d: onehot(m_id), code: ha_response});
      end
      if (m_w >= 0) begin
        m_c.tag = 8'(m_seq * 4 + m_w);
        m_c.com = req_com[m_w];
        m_c.ea = req_ea[m_w];
        m_c.g = onehot(m_w);
        cmd_q.push_back(m_c);
        m_pend[m_w] = 1;
        m_tag_of[m_w] = m_c.tag;
        m_rr = (m_w + 1) % 3;
        m_seq = (m_seq + 1) % 64;
        m_cred--;
        m_just = 1;
        m_just_id = m_w;
        m_just_tag = m_c.tag;
      end
    end
  end
  always @(negedge clk) begin
    cmd_t e;
    rsp_t r;
    if (ah_cvalid) begin
      n_issue++;
      ord_q.push_back(gnt[0] ? 0 : gnt[1] ? 1 : 2);
      tag_q.push_back(ah_ctag);
      chk("cmd_expected", cmd_q.size() != 0, 1);
      if (cmd_q.size() != 0) begin
        e = cmd_q.pop_front();
        chk("ctag", ah_ctag, e.tag);
        chk("com", ah_com, e.com);
        chk("cea", ah_cea, e.ea);
        chk("gnt", gnt, e.g);
      end
    end else begin
      chk("cmd_missing", cmd_q.size(), 0);
      chk("gnt_idle", gnt, 0);
      cmd_q.delete();
    end
    if (|rsp_done) begin
      chk("rsp_expected", rsp_q.size() != 0, 1);
      if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        chk("rsp_done", rsp_done, r.d);
      end
    end else begin
      chk("rsp_missing", rsp_q.size(), 0);
      rsp_q.delete();
    end
    chk("rsp_code", rsp_code, m_code);
    chk("busy", busy, m_pend[0] | m_pend[1] | m_pend[2]);
    chk("tag_err", tag_err, m_terr);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n, input bit imm);
    repeat (n) begin
      step();
      ha_rvalid = imm && m_just;
      ha_rtag = m_just_tag;
      ha_response = 8'($urandom);
    end
  endtask
  task automatic do_reset();
    req = '0;
    ha_rvalid = 0;
    reset = 1;
    run(2, 0);
    reset = 0;
    n_issue = 0;
    ord_q.delete();
    tag_q.delete();
  endtask
  task automatic rand_cycle();
    int s;
    step();
    reset = $urandom % 500 == 0;
    for (int i = 0; i < 3; i++)
      if (m_just && m_just_id == i) req[i] = 0;
      else if (!req[i] && $urandom % 3 == 0) begin
        req[i] = 1;
        s = $urandom % 3;
        req_com[i] = s == 0 ? PSL_CMD_READ : s == 1 ? PSL_CMD_WRITE : 13'($urandom);
        req_ea[i] = {$urandom, $urandom};
      end
    ha_rvalid = 0;
    ha_response = 8'($urandom);
    s = $urandom % 8;
    if (s < 5) begin
      for (int k = 0, b = $urandom % 3; k < 3; k++)
        if (!ha_rvalid && m_pend[(b + k) % 3]) begin
          ha_rvalid = 1;
          ha_rtag = m_tag_of[(b + k) % 3];
        end
    end else if (s == 5) begin
      ha_rvalid = 1;
      ha_rtag = 8'($urandom);
    end
  endtask
  initial begin
    run(2, 0);
    chk("rst_cvalid", ah_cvalid, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", rsp_done, 0);
    chk("rst_code", rsp_code, 0);
    chk("rst_ctag", ah_ctag, 0);
    chk("rst_com", ah_com, 0);
    chk("rst_cea", ah_cea, 0);
    chk("rst_terr", tag_err, 0);
    chk("rst_busy", busy, 0);
    do_reset();
    req_com = {PSL_CMD_WRITE, PSL_CMD_READ, PSL_CMD_WRITE};
    req_ea = {64'h1000, 64'h2000, 64'h3000};
    req = 3'b111;
    run(6, 1);
    chk("rr_count", ord_q.size() >= 4, 1);
    if (ord_q.size() >= 4) begin
      chk("rr_ord0", ord_q[0], 0);
      chk("rr_ord1", ord_q[1], 1);
      chk("rr_ord2", ord_q[2], 2);
      chk("rr_ord3", ord_q[3], 0);
      chk("rr_tag0", tag_q[0], 8'h00);
      chk("rr_tag1", tag_q[1], 8'h05);
      chk("rr_tag2", tag_q[2], 8'h0A);
      chk("rr_tag3", tag_q[3], 8'h0C);
    end
    do_reset();
    req = 3'b111;
    run(6, 0);
    chk("credit_stall", n_issue, 2);
    ha_rvalid = 1;
    ha_rtag = m_tag_of[0];
    run(3, 0);
    chk("credit_return", n_issue, 3);
    chk("credit_winner", ord_q.size() >= 3 ? ord_q[2] : -1, 2);
    ha_rvalid = 1;
    ha_rtag = m_tag_of[1];
    run(1, 0);
    ha_rvalid = 1;
    ha_rtag = m_tag_of[2];
    run(5, 0);
    chk("same_cycle_credit", n_issue, 5);
    chk("same_cycle_ord", ord_q.size() >= 5 ? ord_q[4] : -1, 1);
    ha_rvalid = 1;
    ha_rtag = 8'h03;
    run(2, 0);
    chk("bad_tag_err", tag_err, 1);
    chk("bad_tag_busy", busy, 1);
    chk("bad_tag_no_issue", n_issue, 5);
    do_reset();
    req = 3'b010;
    req_com[1] = PSL_CMD_READ;
    for (int c = 0; c < 400 && n_issue < 65; c++) run(1, 1);
    chk("wrap_count", tag_q.size() >= 65, 1);
    if (tag_q.size() >= 65) begin
      chk("wrap_first", tag_q[0], 8'h01);
      chk("wrap_63", tag_q[63], 8'hFD);
      chk("wrap_back", tag_q[64], 8'h01);
    end
    do_reset();
    req = 3'b111;
    run(3, 0);
    chk("pre_rst_busy", busy, 1);
    req = '0;
    reset = 1;
    run(1, 0);
    reset = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_terr", tag_err, 0);
    ha_rvalid = 1;
    ha_rtag = 8'h05;
    run(1, 0);
    chk("stale_terr", tag_err, 1);
    n_issue = 0;
    req = 3'b111;
    run(5, 0);
    chk("rst_credits", n_issue, 2);
    do_reset();
    repeat (3000) rand_cycle();
    reset = 0;
    req = '0;
    ha_rvalid = 0;
    run(4, 0);
    chk("drain_cmd", cmd_q.size(), 0);
    chk("drain_rsp", rsp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/cmd_arbiter.md
CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 SHALL have parameter CREDITS, default 4: maximum commands outstanding on the PSL command port.
REQ-002 SHALL have parameter NREQ, fixed at 3: requester count (0 = misc/WED, 1 = read, 2 = write).
REQ-003 SHALL have port ha_pclock, in, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, in, 1: synchronous, active-high reset.
REQ-005 SHALL have port req, in, [0:2]: per-requester command request, level, held until granted.
REQ-006 SHALL have ports req_com, in, [0:2][0:12], and req_ea, in, [0:2][0:63]: per-requester command code and effective address.
REQ-007 SHALL have port gnt, out, [0:2]: one-cycle pulse when the requester's command issues.
REQ-008 SHALL have ports ah_cvalid, out, 1; ah_ctag, out, [0:7]; ah_com, out, [0:12]; ah_cea, out, [0:63]: PSL command bus.
REQ-009 SHALL have ports ha_rvalid, in, 1; ha_rtag, in, [0:7]; ha_response, in, [0:7]: PSL response bus.
REQ-010 SHALL have ports rsp_done, out, [0:2], and rsp_code, out, [0:7]: per-requester completion pulse and response code.
REQ-011 SHALL have ports busy, out, 1 (any command outstanding), and tag_err, out, 1 (sticky bad-tag flag).

Function
REQ-012 SHALL treat requester i as eligible when req[i]=1, pending[i]=0 and credits>0.
REQ-013 SHALL select among eligible requesters round-robin, starting from rr_ptr and searching in increasing index with wrap 2->0.
REQ-014 SHALL, in the grant cycle, register ah_cvalid=1, ah_com/ah_cea from the winner and ah_ctag={seq[0:5], id[0:1]}, so the command appears one cycle after the grant decision; gnt[i] pulses in the same cycle as ah_cvalid.
REQ-015 SHALL issue at most one command per cycle; ah_cvalid SHALL be a single-cycle pulse per command.
REQ-016 SHALL set pending[i] on issue and set rr_ptr to (winner+1) mod 3.
REQ-017 SHALL increment the 6-bit seq on every issue, wrapping 63->0.
REQ-018 SHALL decrement credits on issue and increment credits on a valid response; when both occur in the same cycle, credits SHALL be unchanged.
REQ-019 SHALL never let credits exceed CREDITS or drop below 0.
REQ-020 SHALL, on ha_rvalid with ha_rtag[6:7]=i<3 and pending[i]=1, clear pending[i] and, one cycle later, pulse rsp_done[i] with rsp_code=ha_response.
REQ-021 SHALL, on ha_rvalid with ha_rtag[6:7]=3 or pending[i]=0, set tag_err, leave credits and pending unchanged, and pulse no rsp_done.
REQ-022 SHALL allow a response to requester i and a new grant to i in the same cycle only when pending[i] was already 0 before that cycle, i.e. no same-cycle reuse.
REQ-023 SHALL hold rsp_code at its last value when no rsp_done is pulsing.
REQ-024 SHALL drive busy = |pending, combinationally from the registers.

Reset
REQ-025 SHALL, on reset, force ah_cvalid=0, gnt=0, rsp_done=0, rsp_code=0, ah_ctag=0, ah_com=0, ah_cea=0, tag_err=0, pending=0, seq=0, rr_ptr=0 and credits=CREDITS.
REQ-026 SHALL, on reset mid-operation, abandon outstanding commands, ignore any later responses to them (they set tag_err), and issue nothing in the reset cycle.

Structure
REQ-027 SHALL take requester index constants (REQ_MISC=0, REQ_READ=1, REQ_WRITE=2), the PSL command codes (read 13'h0A00, write 13'h0D00) and tag field widths from the shared PSL package.
REQ-028 SHALL contain one sub-module, rr_pick3: a combinational 3-way round-robin selector that takes the eligible vector and rr_ptr and returns a winner and a valid flag.

Verification
REQ-029 SHALL cover: req=3'b111 held, responses returned immediately -> gnt order 0,1,2,0, tags 8'h00, 8'h05, 8'h0A, 8'h0C.
REQ-030 SHALL cover: CREDITS=2, all three request, no responses -> exactly two issues, then stall; one response -> third issues the next cycle.
REQ-031 SHALL cover: response with ha_rtag=8'h03 -> tag_err=1, credits unchanged, no rsp_done.
REQ-032 SHALL cover: issue and response in the same cycle with credits=1 -> credits stays 1.
REQ-033 SHALL cover: 64 issues to requester 1 -> seq wraps and ah_ctag returns to 8'h01.
REQ-034 SHALL cover: reset with two commands outstanding -> busy=0 next cycle, credits=CREDITS, and stale responses set tag_err.
